// File: rtl/mem_pkg.sv
// Shared definitions for the mem_scan_bank block: default parameter values
// and the controller state encoding.
package mem_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_KEYS   = 10;
  localparam int unsigned DEF_DWELL  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary converter with legality check.
// Ports:
//   key   - KEYS-wide one-hot key (bit k set means value k)
//   value - binary index of the set bit (meaningful only when legal)
//   legal - exactly one bit of key is set
module onehot_enc
  import mem_pkg::*;
#(
  parameter int unsigned KEYS   = DEF_KEYS,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [KEYS-1:0]   key,
  output logic [DATA_W-1:0] value,
  output logic              legal
);

  always_comb begin
    value = '0;
    for (int unsigned i = 0; i < KEYS; i++) begin
      if (key[i]) value = value | DATA_W'(i);
    end
    // Non-zero and clearing the lowest set bit leaves nothing: exactly one bit.
    legal = (key != '0) && ((key & (key - 1'b1)) == '0);
  end

endmodule

// File: rtl/mem_scan_bank.sv
// Small key-storage array with registered read port, sequenced clear and
// an auto-scan mode that steps through every address, dwelling on each.
// Ports:
//   CLK, Reset     - clock, synchronous active-high reset
//   WR, RD, A      - write/read strobes and address
//   D_IN           - one-hot key; stored as its binary index
//   CLR            - start a one-entry-per-cycle clear of the array
//   SCAN_EN        - level; cycle Q through all addresses every DWELL cycles
//   Q/Q_VALID/Q_ADDR - registered read/scan data, valid bit and address
//   ERR            - sticky illegal-key flag (cleared by CLR)
//   BUSY           - high while the clear is in progress
module mem_scan_bank
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned KEYS   = DEF_KEYS,
  parameter int unsigned DWELL  = DEF_DWELL
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     WR,
  input  logic                     RD,
  input  logic                     CLR,
  input  logic                     SCAN_EN,
  input  logic [$clog2(DEPTH)-1:0] A,
  input  logic [KEYS-1:0]          D_IN,
  output logic [DATA_W-1:0]        Q,
  output logic                     Q_VALID,
  output logic [$clog2(DEPTH)-1:0] Q_ADDR,
  output logic                     ERR,
  output logic                     BUSY
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned DW_W = $clog2(DWELL + 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                q_valid_q, q_valid_d;
  logic [AW-1:0]       q_addr_q, q_addr_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   key_val;
  logic                key_legal;
  logic                wr_go;
  logic [AW-1:0]       ptr_nxt;
  logic [DATA_W-1:0]   rd_word, scan_word, first_word;

  onehot_enc #(
    .KEYS  (KEYS),
    .DATA_W(DATA_W)
  ) u_enc (
    .key  (D_IN),
    .value(key_val),
    .legal(key_legal)
  );

  // Unwritten entries hold undefined data, so reads are masked by the valid bit.
  always_comb begin
    ptr_nxt    = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    rd_word    = vld_q[A]       ? mem_q[A]       : '0;
    scan_word  = vld_q[ptr_nxt] ? mem_q[ptr_nxt] : '0;
    first_word = vld_q[0]       ? mem_q[0]       : '0;
  end

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    vld_d     = vld_q;
    ptr_d     = ptr_q;
    dwell_d   = dwell_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    q_addr_d  = q_addr_q;
    err_d     = err_q;
    wr_go     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CLR) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          dwell_d = '0;
          err_d   = 1'b0;
        end else begin
          wr_go = WR;
          if (RD) begin
            q_d       = rd_word;
            q_valid_d = vld_q[A];
            q_addr_d  = A;
          end
          // Scan entry loads address 0 on this edge; it owns Q over a read.
          if (SCAN_EN) begin
            state_d   = ST_SCAN;
            ptr_d     = '0;
            dwell_d   = DW_W'(1);
            q_d       = first_word;
            q_valid_d = vld_q[0];
            q_addr_d  = '0;
          end
        end
      end

      ST_CLEAR: begin
        mem_d[ptr_q] = '0;
        vld_d[ptr_q] = 1'b0;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      ST_SCAN: begin
        if (CLR) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          dwell_d = '0;
          err_d   = 1'b0;
        end else begin
          wr_go = WR;
          if (!SCAN_EN) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            dwell_d = '0;
          end else if (dwell_q == DW_W'(DWELL)) begin
            // dwell_q counts cycles already spent on the displayed address.
            ptr_d     = ptr_nxt;
            dwell_d   = DW_W'(1);
            q_d       = scan_word;
            q_valid_d = vld_q[ptr_nxt];
            q_addr_d  = ptr_nxt;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Applied after the reads above, so same-address read sees old contents.
    if (wr_go) begin
      if (key_legal) begin
        mem_d[A] = key_val;
        vld_d[A] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      vld_q     <= '0;
      ptr_q     <= '0;
      dwell_q   <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_addr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      ptr_q     <= ptr_d;
      dwell_q   <= dwell_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_addr_q  <= q_addr_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign Q       = q_q;
  assign Q_VALID = q_valid_q;
  assign Q_ADDR  = q_addr_q;
  assign ERR     = err_q;
  assign BUSY    = (state_q == ST_CLEAR);

endmodule
